spi_reg_ctrl: RTL and testbench

- Configuration controller for the onboarding PWM/output datapath: an SPI-slave, write-only register file.
- Receives 16-bit frames on three asynchronous pins (sclk, copi, ncs) and synchronizes them into clk.
- Decodes each frame and updates five 8-bit control registers, which drive output enables, PWM enables and PWM duty cycle in the top level.

---
 rtl/spi_reg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI-slave, write-only register file: synchronizes sclk/copi/ncs into clk,
// decodes 16-bit frames and drives five 8-bit control registers.
module spi_reg_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = 17;
  localparam int unsigned ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;
  logic                   r_ncs_armed;
  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [7:0]             r_out_lo;
  logic [7:0]             r_out_hi;
  logic [7:0]             r_pwm_lo;
  logic [7:0]             r_pwm_hi;
  logic [7:0]             r_duty;
  logic                   r_frame_done;
  logic                   r_frame_err;

  logic                   w_sclk_s;
  logic                   w_copi_s;
  logic                   w_ncs_s;
  logic                   w_sclk_rise;
  logic                   w_ncs_rise;
  logic                   w_ncs_fall;
  logic                   w_clr;
  logic                   w_shift;
  logic                   w_commit;
  logic                   w_err;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_wr_en;

  // Pin synchronizers: pure data pipes, flushed by the pins themselves.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
    r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
    r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
  // A falling edge only counts once ncs has been seen high since reset.
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev & r_ncs_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
      r_ncs_armed <= 1'b0;
      r_state     <= IDLE;
    end else begin
      r_sclk_prev <= w_sclk_s;
      r_ncs_prev  <= w_ncs_s;
      r_ncs_armed <= r_ncs_armed | w_ncs_s;
      r_state     <= w_state_next;
    end
  end

  // Next-state and datapath strobes; ncs rise has priority over sclk rise.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_shift      = 1'b0;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ncs_fall) begin
          w_clr        = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_ncs_rise) begin
          if (r_cnt == CNT_W'(FRAME_BITS)) begin
            w_state_next = COMMIT;
          end else begin
            w_err        = 1'b1;
            w_state_next = IDLE;
          end
        end else if (w_sclk_rise) begin
          w_shift = 1'b1;
        end
      end
      COMMIT: begin
        w_commit     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_addr  = r_shift[14:8];
  assign w_wr_en = w_commit & r_shift[15] & (w_addr <= ADDR_W'(MAX_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_out_lo     <= 8'h00;
      r_out_hi     <= 8'h00;
      r_pwm_lo     <= 8'h00;
      r_pwm_hi     <= 8'h00;
      r_duty       <= 8'h00;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_commit;
      r_frame_err  <= w_err;
      if (w_clr) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
        if (r_cnt != CNT_W'(CNT_SAT)) begin
          r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
        end
      end
      if (w_wr_en) begin
        case (w_addr)
          7'd0:    r_out_lo <= r_shift[7:0];
          7'd1:    r_out_hi <= r_shift[7:0];
          7'd2:    r_pwm_lo <= r_shift[7:0];
          7'd3:    r_pwm_hi <= r_shift[7:0];
          7'd4:    r_duty   <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_out_lo;
  assign en_reg_out_15_8 = r_out_hi;
  assign en_reg_pwm_7_0  = r_pwm_lo;
  assign en_reg_pwm_15_8 = r_pwm_hi;
  assign pwm_duty_cycle  = r_duty;
  assign frame_done      = r_frame_done;
  assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives SPI frames at pin level and checks
// registers and frame_done/frame_err pulses against hand-computed values.
module tb_spi_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_done;
  logic       frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_base;
  int err_base;

  spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lower ncs and shift nbits of v (right-aligned), MSB first; ncs stays low.
  task automatic shift_bits(input logic [31:0] v, input int nbits);
    ncs = 1'b0;
    wait_clk(6);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
  endtask

  task automatic send_frame(input logic [31:0] v, input int nbits);
    shift_bits(v, nbits);
    ncs = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp);
    check({tag, ".out_lo"}, 32'(en_reg_out_7_0),  32'(exp[7:0]));
    check({tag, ".out_hi"}, 32'(en_reg_out_15_8), 32'(exp[15:8]));
    check({tag, ".pwm_lo"}, 32'(en_reg_pwm_7_0),  32'(exp[23:16]));
    check({tag, ".pwm_hi"}, 32'(en_reg_pwm_15_8), 32'(exp[31:24]));
    check({tag, ".duty"},   32'(pwm_duty_cycle),  32'(exp[39:32]));
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);

    // Reset state
    check_regs("reset", 40'h00_00_00_00_00);
    check("reset.done", 32'(frame_done), 32'd0);
    check("reset.err",  32'(frame_err),  32'd0);

    // Test 1: write 0xFF to addr 0, with exact frame_done latency
    shift_bits(32'h80FF, 16);
    ncs = 1'b1;
    wait_clk(3);
    check("t1.done_early", 32'(frame_done), 32'd0);
    wait_clk(1);
    check("t1.done_pulse", 32'(frame_done), 32'd1);
    check("t1.reg_at_pulse", 32'(en_reg_out_7_0), 32'hFF);
    wait_clk(1);
    check("t1.done_end", 32'(frame_done), 32'd0);
    wait_clk(4);
    check_regs("t1", 40'h00_00_00_00_FF);
    check("t1.done_cnt", 32'(done_cnt), 32'd1);

    // Test 2: duty and pwm_lo writes
    send_frame(32'h8480, 16);
    send_frame(32'h8255, 16);
    check_regs("t2", 40'h80_00_55_00_FF);
    check("t2.done_cnt", 32'(done_cnt), 32'd3);

    // Test 3: read frame and out-of-range write change nothing
    send_frame(32'h00AA, 16);
    send_frame(32'hB012, 16);
    check_regs("t3", 40'h80_00_55_00_FF);
    check("t3.done_cnt", 32'(done_cnt), 32'd5);
    check("t3.err_cnt",  32'(err_cnt),  32'd0);

    // Test 4: short and long frames abort with frame_err
    send_frame(32'h0815, 12);
    check("t4.err12", 32'(err_cnt), 32'd1);
    send_frame(32'h102AA, 17);
    check("t4.err17", 32'(err_cnt), 32'd2);
    check("t4.out_hi",   32'(en_reg_out_15_8), 32'h00);
    check("t4.done_cnt", 32'(done_cnt), 32'd5);

    // Test 5: reset mid-frame, ncs still low at release
    done_base = done_cnt;
    err_base  = err_cnt;
    shift_bits(32'h81, 8);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    ncs = 1'b1;
    wait_clk(10);
    check_regs("t5.cleared", 40'h00_00_00_00_00);
    check("t5.no_done", 32'(done_cnt - done_base), 32'd0);
    check("t5.no_err",  32'(err_cnt - err_base),   32'd0);
    send_frame(32'h8133, 16);
    check_regs("t5.after", 40'h00_00_00_33_00);
    check("t5.done_after", 32'(done_cnt - done_base), 32'd1);

    // Test 6: idle sclk toggling, then back-to-back frames with 2-clk gap
    done_base = done_cnt;
    err_base  = err_cnt;
    for (int i = 0; i < 16; i++) begin
      copi = 1'b1;
      wait_clk(5);
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
    check_regs("t6.idle", 40'h00_00_00_33_00);
    check("t6.idle_done", 32'(done_cnt - done_base), 32'd0);
    shift_bits(32'h0000, 16);
    ncs = 1'b1;
    wait_clk(2);
    send_frame(32'h83C3, 16);
    check_regs("t6", 40'h00_C3_00_33_00);
    check("t6.done", 32'(done_cnt - done_base), 32'd2);
    check("t6.err",  32'(err_cnt - err_base),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
